pio_reg_mem: RTL and testbench

//  Parametrised PIO slave register file; successor to the fixed zero-data PIO stub.

---
 rtl/pio_reg_mem_if.sv | 25 ++
 rtl/pio_reg_mem.sv | 110 +++++++++++
 tb/tb_pio_reg_mem.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pio_reg_mem_if.sv
// PIO strobe bus between the PIO decoder (master) and a register slave.
// Strobes, address and write data flow down; ack, read data and error flow back.
interface pio_reg_mem_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          reg_rd;
    logic          reg_wr;
    logic          reg_ms;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;

    modport master (
        output reg_rd, reg_wr, reg_ms, reg_addr, reg_wdata,
        input  mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  reg_rd, reg_wr, reg_ms, reg_addr, reg_wdata,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/pio_reg_mem.sv
// Parametrised PIO slave register file with clk_div-aligned, wait-stated acks.
// Register contents are exported flat on reg_q, register i at [i*DW +: DW].
module pio_reg_mem #(
    parameter int            DW          = 32,
    parameter int            DEPTH       = 16,
    parameter int            AW          = 4,
    parameter int            WAIT_STATES = 0,
    parameter logic [DW-1:0] RST_VAL     = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_div,
    pio_reg_mem_if.slave        bus,
    output logic [DEPTH*DW-1:0] reg_q
);
    // Index width into the register array; the full address is only used
    // for the range check so that oversized address spaces flag an error.
    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   LIMIT    = DEPTH[AW:0];
    localparam logic [3:0]    CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_wr;
    logic          lat_both;
    logic [DW-1:0] regs [DEPTH];

    logic          start;
    logic          in_range;
    logic [IW-1:0] idx;

    assign start    = bus.reg_ms & (bus.reg_rd | bus.reg_wr);
    assign in_range = ({1'b0, lat_addr} < LIMIT);
    assign idx      = lat_addr[IW-1:0];

    // Access sequencer: accept, count clk_div ticks, perform access with ack rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_wr        <= 1'b0;
            lat_both      <= 1'b0;
            bus.mem_ack   <= 1'b0;
            bus.mem_rdata <= '0;
            bus.mem_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    // The accept cycle never counts as a tick, even with clk_div=1.
                    if (start) begin
                        lat_addr  <= bus.reg_addr;
                        lat_wdata <= bus.reg_wdata;
                        lat_wr    <= bus.reg_wr;
                        lat_both  <= bus.reg_rd & bus.reg_wr;
                        cnt       <= CNT_INIT;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (clk_div) begin
                        if (cnt == '0) begin
                            // Simultaneous rd+wr resolves to a write.
                            if (lat_wr) begin
                                if (in_range) begin
                                    regs[idx] <= lat_wdata;
                                end
                            end else begin
                                bus.mem_rdata <= in_range ? regs[idx] : '0;
                            end
                            bus.mem_err <= lat_both | ~in_range;
                            bus.mem_ack <= 1'b1;
                            state       <= S_ACK;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    // Ack spans exactly one clk_div period; rdata stays held.
                    if (clk_div) begin
                        bus.mem_ack <= 1'b0;
                        bus.mem_err <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Flat export of the register array to the owning block.
    for (genvar i = 0; i < DEPTH; i++) begin : g_q
        assign reg_q[i*DW +: DW] = regs[i];
    end
endmodule

// File: tb/tb_pio_reg_mem.sv
// Bench for pio_reg_mem: directed latency checks plus randomized accesses
// against a transaction-level model counting clk_div ticks per access.
module tb_pio_reg_mem;
    localparam int            DW    = 32;
    localparam int            DEPTH = 16;
    localparam int            WS    = 2;
    localparam logic [DW-1:0] RV    = 32'hA5A5_0000;

    logic                clk  = 1'b0;
    logic                rst  = 1'b1;
    logic                cdiv = 1'b0;
    logic [DEPTH*DW-1:0] q0;
    logic [DEPTH*DW-1:0] q;

    pio_reg_mem_if #(.DW(DW), .AW(4)) b0 ();
    pio_reg_mem_if #(.DW(DW), .AW(5)) b ();

    pio_reg_mem #(
        .DW(DW), .DEPTH(DEPTH), .AW(4), .WAIT_STATES(0), .RST_VAL(32'h0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .clk_div(1'b1), .bus(b0), .reg_q(q0)
    );

    pio_reg_mem #(
        .DW(DW), .DEPTH(DEPTH), .AW(5), .WAIT_STATES(WS), .RST_VAL(RV)
    ) u_dut (
        .clk(clk), .rst(rst), .clk_div(cdiv), .bus(b), .reg_q(q)
    );

    always #5 clk = ~clk;

    // clk_div pattern: 0 = always on, 1 = every 4th cycle, 2 = random.
    int          cmode = 0;
    int unsigned cyc   = 0;
    always @(negedge clk) begin
        cyc++;
        case (cmode)
            0:       cdiv = 1'b1;
            1:       cdiv = ((cyc % 4) == 0);
            default: cdiv = ($urandom_range(0, 2) == 0);
        endcase
    end

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] m_rdata;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DEPTH*DW-1:0] flat();
        logic [DEPTH*DW-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*DW +: DW] = mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = RV;
        m_rdata = '0;
    endtask

    task automatic bus_idle();
        b.reg_rd    = 1'b0;
        b.reg_wr    = 1'b0;
        b.reg_ms    = 1'b0;
        b.reg_addr  = '0;
        b.reg_wdata = '0;
    endtask

    // One access on the wait-stated DUT; ack expected on the (WS+1)-th
    // clk_div tick after accept, dropping on the next tick.
    task automatic access(input logic rd, input logic wr, input logic ms,
                          input logic [4:0] a, input logic [31:0] d,
                          input bit noise);
        int ticks;
        bit t;
        bit acked;
        bit done;
        bit in;
        logic [31:0] er;
        in = (a < 5'(DEPTH));
        @(negedge clk);
        b.reg_rd = rd; b.reg_wr = wr; b.reg_ms = ms;
        b.reg_addr = a; b.reg_wdata = d;
        @(posedge clk); #1;
        check("ack_accept", 512'(b.mem_ack), 512'(1'b0));
        check("rdata_hold", 512'(b.mem_rdata), 512'(m_rdata));
        if (!(ms & (rd | wr))) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("ack_nosel", 512'(b.mem_ack), 512'(1'b0));
            end
            @(negedge clk);
            bus_idle();
            return;
        end
        ticks = 0; acked = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (acked) begin
                bus_idle();
            end else if (noise) begin
                b.reg_rd    = 1'($urandom);
                b.reg_wr    = 1'($urandom);
                b.reg_ms    = 1'($urandom);
                b.reg_addr  = 5'($urandom);
                b.reg_wdata = $urandom;
            end
            @(posedge clk);
            t = cdiv;
            #1;
            if (t) ticks++;
            check("ack", 512'(b.mem_ack), 512'(ticks == WS + 1));
            if (t && ticks == WS + 1) begin
                acked = 1;
                er = wr ? m_rdata : (in ? mdl[a[3:0]] : 32'h0);
                if (wr && in) mdl[a[3:0]] = d;
                m_rdata = er;
                check("rdata", 512'(b.mem_rdata), 512'(m_rdata));
                check("err", 512'(b.mem_err), 512'((rd & wr) | !in));
                check("regq", 512'(q), 512'(flat()));
            end
            if (ticks == WS + 2) begin
                done = 1;
                check("err_clr", 512'(b.mem_err), 512'(1'b0));
            end
        end
        check("timeout", 512'(done), 512'(1'b1));
    endtask

    task automatic reset_mid();
        @(negedge clk);
        b.reg_wr = 1'b1; b.reg_ms = 1'b1;
        b.reg_addr = 5'd7; b.reg_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_idle();
        @(posedge clk); #1;
        model_reset();
        check("rst_ack", 512'(b.mem_ack), 512'(1'b0));
        check("rst_rdata", 512'(b.mem_rdata), 512'(m_rdata));
        check("rst_err", 512'(b.mem_err), 512'(1'b0));
        check("rst_regq", 512'(q), 512'(flat()));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed WS=0 sequence on the unity-divider instance.
    task automatic dut0_seq();
        logic [31:0] v;
        bit exp_ack [5];
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        b0.reg_wr = 1'b1; b0.reg_ms = 1'b1;
        b0.reg_addr = 4'd3; b0.reg_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("d0_t0_ack", 512'(b0.mem_ack), 512'(1'b0));
        @(posedge clk); #1;
        check("d0_t1_ack", 512'(b0.mem_ack), 512'(1'b1));
        check("d0_t1_err", 512'(b0.mem_err), 512'(1'b0));
        @(negedge clk);
        b0.reg_wr = 1'b0; b0.reg_ms = 1'b0;
        @(posedge clk); #1;
        v = q0[3*DW +: DW];
        check("d0_t2_ack", 512'(b0.mem_ack), 512'(1'b0));
        check("d0_t2_regq", 512'(v), 512'(32'hDEAD_BEEF));
        // Held read strobe: back-to-back accesses, one idle cycle between acks.
        @(negedge clk);
        b0.reg_rd = 1'b1; b0.reg_ms = 1'b1; b0.reg_addr = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("d0_b2b_ack", 512'(b0.mem_ack), 512'(exp_ack[i]));
            if (exp_ack[i])
                check("d0_rdata", 512'(b0.mem_rdata), 512'(32'hDEAD_BEEF));
        end
        @(negedge clk);
        b0.reg_rd = 1'b0; b0.reg_ms = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("d0_idle_ack", 512'(b0.mem_ack), 512'(1'b0));
            check("d0_rdata_held", 512'(b0.mem_rdata), 512'(32'hDEAD_BEEF));
        end
    endtask

    initial begin
        logic [1:0] op;
        bus_idle();
        b0.reg_rd = 1'b0; b0.reg_wr = 1'b0; b0.reg_ms = 1'b0;
        b0.reg_addr = '0; b0.reg_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst0_ack", 512'(b.mem_ack), 512'(1'b0));
        check("rst0_rdata", 512'(b.mem_rdata), 512'(32'h0));
        check("rst0_err", 512'(b.mem_err), 512'(1'b0));
        check("rst0_regq", 512'(q), 512'(flat()));
        check("rst0_q0", 512'(q0), 512'(0));
        @(negedge clk);
        rst = 1'b0;

        dut0_seq();

        cmode = 1;
        access(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 1'b0);
        access(1'b0, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 1'b0);
        access(1'b1, 1'b0, 1'b1, 5'd20, 32'h0, 1'b0);
        access(1'b0, 1'b1, 1'b1, 5'd20, 32'h1111_2222, 1'b0);
        access(1'b1, 1'b1, 1'b1, 5'd5, 32'h55, 1'b1);
        access(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 1'b0);
        access(1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 1'b0);
        reset_mid();
        access(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            cmode = $urandom_range(0, 2);
            op    = 2'($urandom);
            access(op != 2'd1, op != 2'd0 && op != 2'd3,
                   $urandom_range(0, 9) != 0,
                   5'($urandom_range(0, 23)), $urandom,
                   $urandom_range(0, 1) == 1);
        end
        cmode = 1;
        reset_mid();
        access(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
